// File: rtl/qs_enq_if.sv
// Input packet stream of the quicksort enqueue stage.
interface qs_enq_if #(
  parameter int W = 32
);
  // A word transfers on a rising clock edge where in_vld & in_rdy_r are both high.
  // While in_vld is high and in_rdy_r low the source holds in_sop/in_eop/in_dat stable.
  logic         in_vld;
  logic         in_sop;
  logic         in_eop;
  logic [W-1:0] in_dat;
  logic         in_rdy_r;

  modport master (output in_vld, output in_sop, output in_eop, output in_dat, input in_rdy_r);
  modport slave  (input in_vld, input in_sop, input in_eop, input in_dat, output in_rdy_r);
endinterface

// File: rtl/qs_enq.sv
// Quicksort enqueue stage: writes one packet per bank into SRAM, then publishes the bank
// as LOADED with its last-word index and error flag, visiting banks round-robin.
module qs_enq #(
  parameter int W       = 32,
  parameter int N       = 16,
  parameter int BANKS_N = 2,
  localparam int AW     = (N > 1) ? $clog2(N) : 1,
  localparam int BW     = (BANKS_N > 1) ? $clog2(BANKS_N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  qs_enq_if.slave       in_if,
  input  logic [2:0]    bnk_in_status,
  output logic          bnk_out_vld_r,
  output logic [2:0]    bnk_out_status,
  output logic [AW-1:0] bnk_out_n_r,
  output logic          bnk_out_err_r,
  output logic [BW-1:0] bnk_idx_r,
  output logic          enq_wr_en_r,
  output logic [AW-1:0] enq_wr_addr_r,
  output logic [W-1:0]  enq_wr_data_r,
  output logic [1:0]    dbg_state
);
  localparam logic [2:0]    ST_READY  = 3'd0;
  localparam logic [2:0]    ST_LOADED = 3'd1;
  localparam logic [AW-1:0] IDX_MAX   = AW'(N - 1);
  localparam logic [BW-1:0] BNK_MAX   = BW'(BANKS_N - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PUB = 2'd2} state_t;
  state_t state, nxt;

  logic [AW-1:0] idx;
  logic          err, open_pkt, full;
  logic          acc, take, wr, done, err_nxt;

  // take: word belongs to a packet; full: address N-1 already written, so further words overflow
  always_comb begin
    acc     = (state == S_LOAD) & in_if.in_vld & in_if.in_rdy_r;
    take    = acc & (open_pkt | in_if.in_sop);
    wr      = take & ~full;
    done    = take & in_if.in_eop;
    err_nxt = err | (take & full) | (acc & open_pkt & in_if.in_sop);
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bnk_in_status == ST_READY) nxt = S_LOAD;
      S_LOAD:  if (done) nxt = S_PUB;
      S_PUB:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_if.in_rdy_r <= 1'b0;
      enq_wr_en_r    <= 1'b0;
      enq_wr_addr_r  <= '0;
      enq_wr_data_r  <= '0;
      bnk_out_vld_r  <= 1'b0;
      bnk_out_n_r    <= '0;
      bnk_out_err_r  <= 1'b0;
      bnk_idx_r      <= '0;
      idx            <= '0;
      err            <= 1'b0;
      open_pkt       <= 1'b0;
      full           <= 1'b0;
    end else begin
      in_if.in_rdy_r <= (nxt == S_LOAD);
      enq_wr_en_r    <= wr;
      bnk_out_vld_r  <= done;
      if (wr) begin
        enq_wr_addr_r <= idx;
        enq_wr_data_r <= in_if.in_dat;
      end
      // idx saturates, so it is the last written address even when the eop word overflowed
      if (done) begin
        bnk_out_n_r   <= idx;
        bnk_out_err_r <= err_nxt;
      end
      case (state)
        S_IDLE: if (nxt == S_LOAD) begin
          idx      <= '0;
          err      <= 1'b0;
          open_pkt <= 1'b0;
          full     <= 1'b0;
        end
        S_LOAD: if (take) begin
          open_pkt <= ~done;
          err      <= err_nxt;
          if (wr) begin
            if (idx == IDX_MAX) full <= 1'b1;
            else                idx  <= idx + AW'(1);
          end
        end
        // advance only after the publish cycle so the owner writes LOADED into the right bank
        S_PUB: bnk_idx_r <= (bnk_idx_r == BNK_MAX) ? '0 : bnk_idx_r + BW'(1);
        default: ;
      endcase
    end
  end

  assign bnk_out_status = bnk_out_vld_r ? ST_LOADED : ST_READY;
  assign dbg_state      = state;
endmodule

// File: tb/tb_qs_enq.sv
// Bench for qs_enq: emulated bank-status owner, packet-level reference model, per-cycle compare.
module tb_qs_enq;
  localparam int W = 32, N = 16, B = 2, AW = 4, BW = 1;

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [AW-1:0] n;
    logic          err;
  } pub_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qs_enq_if #(.W(W)) bus ();
  logic [2:0]    bnk_in_status;
  logic          bnk_out_vld_r;
  logic [2:0]    bnk_out_status;
  logic [AW-1:0] bnk_out_n_r;
  logic          bnk_out_err_r;
  logic [BW-1:0] bnk_idx_r;
  logic          enq_wr_en_r;
  logic [AW-1:0] enq_wr_addr_r;
  logic [W-1:0]  enq_wr_data_r;
  logic [1:0]    dbg_state;

  qs_enq #(.W(W), .N(N), .BANKS_N(B)) dut (
    .clk(clk), .rst(rst), .in_if(bus),
    .bnk_in_status(bnk_in_status), .bnk_out_vld_r(bnk_out_vld_r),
    .bnk_out_status(bnk_out_status), .bnk_out_n_r(bnk_out_n_r),
    .bnk_out_err_r(bnk_out_err_r), .bnk_idx_r(bnk_idx_r),
    .enq_wr_en_r(enq_wr_en_r), .enq_wr_addr_r(enq_wr_addr_r),
    .enq_wr_data_r(enq_wr_data_r), .dbg_state(dbg_state)
  );

  // ---------------- bank status owner ----------------
  logic [2:0]    bank_st [B];
  logic          auto_rel = 1'b0;
  logic          set_req  = 1'b0;
  logic [BW-1:0] set_bank = '0;
  logic [2:0]    set_val  = 3'd0;
  assign bnk_in_status = bank_st[bnk_idx_r];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < B; i++) bank_st[i] <= 3'd0;
    end else begin
      for (int i = 0; i < B; i++)
        if (auto_rel && bank_st[i] == 3'd1 && $urandom_range(0, 3) == 0) bank_st[i] <= 3'd0;
      if (set_req) bank_st[set_bank] <= set_val;
      if (bnk_out_vld_r) bank_st[bnk_idx_r] <= 3'd1;
    end
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_bad = 0;
  logic [AW+W-1:0] exp_q [$];
  pub_t            pub_q [$];
  pub_t            act_log [$];
  logic [AW+W-1:0] wr_log [$];
  int   pkt_cnt = 0, pkt_len = 0, sent_pkts = 0;
  bit   pkt_open = 0, pkt_err = 0, prev_vld = 0;
  logic [AW+W-1:0] e_wr;
  pub_t e_pub, m_pub;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: first N words of a packet land at 0..N-1, the rest are lost.
  task automatic model_step();
    if (rst) begin
      pkt_cnt = 0; pkt_open = 0; pkt_len = 0; pkt_err = 0;
      exp_q.delete(); pub_q.delete();
      return;
    end
    if (bus.in_vld && bus.in_rdy_r) begin
      if (!pkt_open && bus.in_sop) begin
        pkt_open = 1; pkt_len = 0; pkt_err = 0;
      end else if (pkt_open && bus.in_sop) pkt_err = 1;
      if (pkt_open) begin
        if (pkt_len < N) exp_q.push_back({AW'(pkt_len), bus.in_dat});
        else             pkt_err = 1;
        pkt_len++;
        if (bus.in_eop) begin
          m_pub.bank = BW'(pkt_cnt % B);
          m_pub.n    = AW'(((pkt_len < N) ? pkt_len : N) - 1);
          m_pub.err  = pkt_err;
          pub_q.push_back(m_pub);
          pkt_cnt++;
          pkt_open = 0;
        end
      end
    end
  endtask

  task automatic compare_step();
    chk("wr_en", 64'(enq_wr_en_r), 64'(exp_q.size() != 0));
    if (enq_wr_en_r) wr_log.push_back({enq_wr_addr_r, enq_wr_data_r});
    if (exp_q.size() != 0) begin
      e_wr = exp_q.pop_front();
      if (enq_wr_en_r) begin
        chk("wr_addr", 64'(enq_wr_addr_r), 64'(e_wr[AW+W-1:W]));
        chk("wr_data", 64'(enq_wr_data_r), 64'(e_wr[W-1:0]));
      end
    end
    chk("pub_vld", 64'(bnk_out_vld_r), 64'(pub_q.size() != 0));
    if (bnk_out_vld_r) act_log.push_back({bnk_idx_r, bnk_out_n_r, bnk_out_err_r});
    if (pub_q.size() != 0) begin
      e_pub = pub_q.pop_front();
      if (bnk_out_vld_r) begin
        chk("pub_bank",   64'(bnk_idx_r), 64'(e_pub.bank));
        chk("pub_n",      64'(bnk_out_n_r), 64'(e_pub.n));
        chk("pub_err",    64'(bnk_out_err_r), 64'(e_pub.err));
        chk("pub_status", 64'(bnk_out_status), 64'd1);
      end
    end else begin
      chk("bnk_idx", 64'(bnk_idx_r), 64'(pkt_cnt % B));
    end
    if (bnk_out_vld_r || prev_vld) chk("rdy_gap", 64'(bus.in_rdy_r), 64'd0);
    prev_vld = bnk_out_vld_r;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic s, input logic e, input logic [W-1:0] d);
    int t;
    @(negedge clk);
    bus.in_vld = 1'b1; bus.in_sop = s; bus.in_eop = e; bus.in_dat = d;
    t = 0;
    do begin @(posedge clk); t++; end while (!bus.in_rdy_r && t < 400);
    if (!bus.in_rdy_r) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no ready, want ready within 400 cycles");
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    end
  endtask

  task automatic set_bank_st(input logic [BW-1:0] b, input logic [2:0] v);
    @(negedge clk);
    set_req = 1'b1; set_bank = b; set_val = v;
    @(negedge clk);
    set_req = 1'b0;
  endtask

  task automatic wait_pubs(input int target);
    int t;
    t = 0;
    while (act_log.size() < target && t < 400) begin
      @(negedge clk); #1; t++;
    end
    chk("pub_wait", 64'(act_log.size() >= target), 64'd1);
  endtask

  task automatic send_pkt(input int len, input logic [W-1:0] base);
    for (int i = 0; i < len; i++) send_word(i == 0, i == len - 1, base + W'(i));
    idle(1);
  endtask

  task automatic chk_pub(input string name, input int k, input int bank, input int n, input int err);
    if (k < act_log.size()) begin
      chk({name, "_bank"}, 64'(act_log[k].bank), 64'(bank));
      chk({name, "_n"},    64'(act_log[k].n), 64'(n));
      chk({name, "_err"},  64'(act_log[k].err), 64'(err));
    end else chk({name, "_missing"}, 64'(act_log.size()), 64'(k + 1));
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_wr_en"}, 64'(enq_wr_en_r), 64'd0);
    chk({name, "_wr_addr"}, 64'(enq_wr_addr_r), 64'd0);
    chk({name, "_wr_data"}, 64'(enq_wr_data_r), 64'd0);
    chk({name, "_vld"}, 64'(bnk_out_vld_r), 64'd0);
    chk({name, "_n"}, 64'(bnk_out_n_r), 64'd0);
    chk({name, "_err"}, 64'(bnk_out_err_r), 64'd0);
    chk({name, "_status"}, 64'(bnk_out_status), 64'd0);
    chk({name, "_idx"}, 64'(bnk_idx_r), 64'd0);
    chk({name, "_rdy"}, 64'(bus.in_rdy_r), 64'd0);
  endtask

  // ---------------- stimulus and report ----------------
  initial begin
    int base, base_rst, len;
    bus.in_vld = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_dat = '0;
    fork
      forever begin @(posedge clk or posedge rst); model_step(); end
      forever begin @(negedge clk); if (rst) prev_vld = 0; else compare_step(); end
    join_none

    repeat (3) @(negedge clk);
    #1 chk_zero_outputs("reset");
    @(negedge clk); rst = 1'b0;

    // 4-word packet into bank 0
    wr_log.delete(); base = act_log.size();
    for (int i = 0; i < 4; i++) send_word(i == 0, i == 3, W'(32'hA + i));
    idle(1);
    wait_pubs(base + 1);
    chk_pub("t1", base, 0, 3, 0);
    chk("t1_writes", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk("t1_wr", 64'(wr_log[i]), {28'd0, 4'(i), 32'hA + 32'(i)});
    @(negedge clk); chk("t1_idx_next", 64'(bnk_idx_r), 64'd1);

    // single-word packet into bank 1
    wr_log.delete(); base = act_log.size();
    send_word(1'b1, 1'b1, 32'h5555_0001); idle(1);
    wait_pubs(base + 1);
    chk_pub("t2", base, 1, 0, 0);
    chk("t2_writes", 64'(wr_log.size()), 64'd1);

    // N+2 words: two overflow words are lost
    set_bank_st(0, 3'd0);
    wr_log.delete(); base = act_log.size();
    send_pkt(N + 2, 32'h100);
    wait_pubs(base + 1);
    chk_pub("t3", base, 0, N - 1, 1);
    chk("t3_writes", 64'(wr_log.size()), 64'(N));
    if (wr_log.size() == N) chk("t3_last_wr", 64'(wr_log[N-1]), {28'd0, 4'(N - 1), 32'h10F});

    // bank 1 SORTED stalls the stage until it is READY again
    set_bank_st(1, 3'd3);
    repeat (10) @(negedge clk);
    chk("t4_stall", 64'(bus.in_rdy_r), 64'd0);
    set_bank_st(1, 3'd0);
    chk("t4_rdy_before", 64'(bus.in_rdy_r), 64'd0);
    @(negedge clk); chk("t4_rdy_rise", 64'(bus.in_rdy_r), 64'd1);
    wr_log.delete(); base = act_log.size();
    send_pkt(5, 32'h200);
    wait_pubs(base + 1);
    chk_pub("t4", base, 1, 4, 0);
    chk("t4_writes", 64'(wr_log.size()), 64'd5);

    // three back-to-back packets, bank pointer wraps
    auto_rel = 1'b1;
    base = act_log.size();
    for (int i = 0; i < 3; i++) send_word(i == 0, i == 2, W'(32'h300 + i));
    for (int i = 0; i < 7; i++) send_word(i == 0, i == 6, W'(32'h400 + i));
    for (int i = 0; i < 2; i++) send_word(i == 0, i == 1, W'(32'h500 + i));
    idle(1);
    wait_pubs(base + 3);
    chk_pub("t5a", base, 0, 2, 0);
    chk_pub("t5b", base + 1, 1, 6, 0);
    chk_pub("t5c", base + 2, 0, 1, 0);
    @(negedge clk); chk("t5_idx_wrap", 64'(bnk_idx_r), 64'd1);

    // reset in mid-packet
    for (int i = 0; i < 3; i++) send_word(i == 0, 1'b0, W'(32'h600 + i));
    @(negedge clk);
    bus.in_vld = 1'b0; bus.in_sop = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero_outputs("t6_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t6_idx_after", 64'(bnk_idx_r), 64'd0);
    wr_log.delete(); base = act_log.size(); base_rst = base;
    send_pkt(4, 32'h700);
    wait_pubs(base + 1);
    chk_pub("t6", base, 0, 3, 0);
    if (wr_log.size() > 0) chk("t6_first_wr", 64'(wr_log[0]), {28'd0, 4'd0, 32'h700});
    sent_pkts = 1;

    // randomized packets: garbage before sop, stray sop, overflow, gaps
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) == 0) send_word(1'b0, 1'($urandom_range(0, 1)), $urandom);
      len = $urandom_range(1, N + 3);
      for (int i = 0; i < len; i++) begin
        send_word((i == 0) || ($urandom_range(0, 19) == 0), i == len - 1, $urandom);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      sent_pkts++;
    end
    idle(1);
    wait_pubs(base_rst + sent_pkts);
    repeat (5) @(negedge clk);
    #1;
    chk("drain_wr_q", 64'(exp_q.size()), 64'd0);
    chk("drain_pub_q", 64'(pub_q.size()), 64'd0);
    chk("pub_total", 64'(act_log.size() - base_rst), 64'(sent_pkts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
